// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/data memory port arbiter.
// The state codes, the NOP instruction and the word-access DMType code live here.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_BUSY = 2'd1;
  localparam logic [1:0] ST_DM_BUSY = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Word access code, matching dm_word in ctrl_encode_def.
  localparam logic [2:0] DMTYPE_WORD = 3'b000;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear.
// tc is raised during the TIMEOUT_CYC-th enabled cycle, so the owner sees exactly TIMEOUT_CYC bus cycles.
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MIO bus between the CPU fetch port and the data port, one access at a time.
// Data wins arbitration, but after MAX_DM_RUN data grants a waiting fetch is served.
//
//   state      | meaning
//   IDLE       | bus quiet, arbitrate on if_req/dm_req
//   IF_BUSY    | fetch on the bus, waiting for bus_ready or timeout
//   DM_BUSY    | data access on the bus, waiting for bus_ready or timeout
//   RESP       | owner's ready pulse (and bus_err on abort), bus released
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DM_RUN  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_type,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [2:0]  bus_type,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_err
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_DM_RUN);

  logic [1:0]  state_q, state_d;
  logic [3:0]  dm_run_q, dm_run_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [2:0]  bus_type_q, bus_type_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        dm_ready_q, dm_ready_d;
  logic        bus_err_q, bus_err_d;

  logic grant;
  logic busy;
  logic to_tc;

  assign busy = (state_q == ST_IF_BUSY) || (state_q == ST_DM_BUSY);

  arb_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(grant),
    .en (busy),
    .tc (to_tc)
  );

  always_comb begin
    state_d     = state_q;
    dm_run_d    = dm_run_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_type_d  = bus_type_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    bus_err_d   = 1'b0;
    grant       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dm_req && (!if_req || (dm_run_q < RUN_MAX))) begin
          grant       = 1'b1;
          state_d     = ST_DM_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = dm_we;
          bus_type_d  = dm_type;
          bus_addr_d  = dm_addr;
          bus_wdata_d = dm_wdata;
          // The run only counts grants that actually held a fetch back.
          if (!if_req) begin
            dm_run_d = '0;
          end else if (dm_run_q < RUN_MAX) begin
            dm_run_d = dm_run_q + 4'd1;
          end
        end else if (if_req) begin
          grant      = 1'b1;
          state_d    = ST_IF_BUSY;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_type_d = DMTYPE_WORD;
          bus_addr_d = if_addr;
          dm_run_d   = '0;
        end
      end
      ST_IF_BUSY: begin
        if (bus_ready || to_tc) begin
          state_d    = ST_RESP;
          bus_req_d  = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = bus_ready ? bus_rdata : NOP_INSTR;
          bus_err_d  = !bus_ready;
        end
      end
      ST_DM_BUSY: begin
        if (bus_ready || to_tc) begin
          state_d    = ST_RESP;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          dm_ready_d = 1'b1;
          bus_err_d  = !bus_ready;
          if (!bus_we_q) begin
            dm_rdata_d = bus_ready ? bus_rdata : 32'h0;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dm_run_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_type_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dm_run_q    <= dm_run_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_type_q  <= bus_type_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_type  = bus_type_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, plus a
// transaction-schedule model compared against the outputs every cycle.
module tb_mem_port_arbiter;

  localparam int MAX_RUN = 4;
  localparam int TO      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready;
  logic [2:0]  dm_type;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        bus_req, bus_we, bus_ready, bus_err;
  logic [2:0]  bus_type;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // slave and requester controls
  int          slave_delay = 0;
  logic [31:0] slave_data  = 32'h0;
  logic        stray_ready = 1'b0;
  logic        scramble    = 1'b0;
  int          s_cnt       = 0;
  int          if_left     = 0;
  int          dm_left     = 0;

  // model state
  int          m_c = 0, m_L = 0, m_run = 0;
  logic        m_err = 1'b0, m_dm = 1'b0, m_we = 1'b0;
  logic [2:0]  m_type = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_val = '0, m_if_rdata = '0, m_dm_rdata = '0;
  logic        exp_busy, exp_resp;

  mem_port_arbiter #(.MAX_DM_RUN(MAX_RUN), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_type(bus_type), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait budget expired (t=%0t)", nm, $time);
  endtask

  // Slave: answers after slave_delay wait cycles (negative = never); rdata is junk off the ready cycle.
  initial forever begin
    @(negedge clk);
    if (bus_req === 1'b1) begin
      bus_ready = (s_cnt == slave_delay);
      bus_rdata = (s_cnt == slave_delay) ? slave_data : $urandom;
      s_cnt++;
    end else begin
      bus_ready = stray_ready;
      bus_rdata = $urandom;
      s_cnt     = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (if_req && if_ready) begin
      if_left--;
      if (if_left <= 0) if_req = 1'b0;
      else if_addr = if_addr + 32'd4;
    end
  end

  initial forever begin
    @(negedge clk);
    if (dm_req && dm_ready) begin
      dm_left--;
      if (dm_left <= 0) dm_req = 1'b0;
      else begin
        dm_addr  = dm_addr + 32'd4;
        dm_wdata = dm_wdata + 32'd1;
      end
    end else if (dm_req && scramble) begin
      dm_wdata = $urandom;
      dm_type  = 3'($urandom);
    end
  end

  // Model: at grant, the whole access is scheduled from the slave's known delay:
  // L bus cycles, then one response cycle, then one idle cycle before the next grant.
  initial begin : compare
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_c = 0; m_L = 0; m_run = 0; m_err = 1'b0; m_dm = 1'b0;
        m_if_rdata = '0; m_dm_rdata = '0;
      end else if (m_c == 0) begin
        if (dm_req || if_req) begin
          m_dm = dm_req && (!if_req || m_run < MAX_RUN);
          if (m_dm) begin
            m_addr = dm_addr; m_we = dm_we; m_type = dm_type; m_wdata = dm_wdata;
            m_run  = if_req ? ((m_run < MAX_RUN) ? m_run + 1 : m_run) : 0;
          end else begin
            m_addr = if_addr; m_we = 1'b0; m_type = 3'b000; m_run = 0;
          end
          m_err = (slave_delay < 0) || (slave_delay >= TO);
          m_L   = m_err ? TO : slave_delay + 1;
          m_val = slave_data;
          m_c   = 1;
        end
      end else if (m_c == m_L + 1) begin
        m_c = 0;
      end else begin
        m_c++;
        if (m_c == m_L + 1) begin
          if (m_dm) begin
            if (!m_we) m_dm_rdata = m_err ? 32'h0 : m_val;
          end else begin
            m_if_rdata = m_err ? 32'h0000_0013 : m_val;
          end
        end
      end
      #1;
      exp_busy = (m_c >= 1) && (m_c <= m_L);
      exp_resp = (m_c != 0) && (m_c == m_L + 1);
      chk("model_bus_req",  32'(bus_req),  32'(exp_busy));
      chk("model_bus_we",   32'(bus_we),   32'(exp_busy && m_dm && m_we));
      chk("model_if_ready", 32'(if_ready), 32'(exp_resp && !m_dm));
      chk("model_dm_ready", 32'(dm_ready), 32'(exp_resp && m_dm));
      chk("model_bus_err",  32'(bus_err),  32'(exp_resp && m_err));
      chk("model_if_rdata", if_rdata, m_if_rdata);
      chk("model_dm_rdata", dm_rdata, m_dm_rdata);
      if (exp_busy) begin
        chk("model_bus_addr", bus_addr, m_addr);
        chk("model_bus_type", 32'(bus_type), 32'(m_type));
        if (m_dm) chk("model_bus_wdata", bus_wdata, m_wdata);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((if_req || dm_req || m_c != 0) && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= budget) timeout_fail("wait_idle");
  endtask

  task automatic wait_grant(output logic is_fetch);
    int k = 0;
    while (bus_req !== 1'b0 && k < 40) begin @(posedge clk); #1; k++; end
    while (bus_req !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    if (k >= 40) timeout_fail("wait_grant");
    is_fetch = (bus_addr < 32'h1000);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    @(posedge clk); #1;
    while (bus_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin : stim
    logic [6:0] seq;
    logic       f;
    int         cnt;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_type = 3'b010; dm_addr = '0; dm_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req",  32'(bus_req),  32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_bus_err",  32'(bus_err),  32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    rst = 1'b1;

    // lone fetch, slave ready in first bus cycle
    @(negedge clk);
    slave_delay = 0; slave_data = 32'hDEADBEEF;
    if_addr = 32'h100; if_left = 1; if_req = 1'b1;
    @(posedge clk); #1;
    chk("t1_bus_req",  32'(bus_req), 32'd1);
    chk("t1_bus_addr", bus_addr, 32'h100);
    chk("t1_bus_we",   32'(bus_we), 32'd0);
    @(posedge clk); #1;
    chk("t1_if_ready", 32'(if_ready), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    wait_idle(20);

    // collision: store wins, fetch follows at the next idle; stray bus_ready outside busy
    @(negedge clk);
    stray_ready = 1'b1; slave_delay = 0; slave_data = 32'h1111_2222;
    dm_addr = 32'h2000; dm_wdata = 32'h55; dm_we = 1'b1; dm_left = 1;
    if_addr = 32'h200; if_left = 1;
    if_req = 1'b1; dm_req = 1'b1;
    @(posedge clk); #1;
    chk("t2_bus_we",    32'(bus_we), 32'd1);
    chk("t2_bus_wdata", bus_wdata, 32'h55);
    chk("t2_bus_addr",  bus_addr, 32'h2000);
    @(posedge clk); #1;
    chk("t2_dm_ready",  32'(dm_ready), 32'd1);
    chk("t2_dm_rdata",  dm_rdata, 32'd0);
    @(posedge clk); #1;
    chk("t2_idle_gap",  32'(bus_req), 32'd0);
    @(posedge clk); #1;
    chk("t2_if_grant",  bus_addr, 32'h200);
    wait_idle(20);
    stray_ready = 1'b0;

    // starvation guard: six loads queued with one fetch waiting
    @(negedge clk);
    slave_delay = 0; slave_data = 32'h0BAD_0000;
    dm_we = 1'b0; dm_addr = 32'h4000; dm_left = 6; if_addr = 32'h300; if_left = 1;
    dm_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_grant(f);
      seq[k] = f;
    end
    chk("t3_order", 32'(seq), 32'h10);
    wait_idle(30);

    // timeout on a fetch
    @(negedge clk);
    slave_delay = -1; if_addr = 32'h500; if_left = 1; if_req = 1'b1;
    count_busy(cnt);
    chk("t4_busy_cycles", 32'(cnt), 32'd8);
    chk("t4_if_ready", 32'(if_ready), 32'd1);
    chk("t4_bus_err",  32'(bus_err), 32'd1);
    chk("t4_if_rdata", if_rdata, 32'h0000_0013);
    @(posedge clk); #1;
    chk("t4_bus_req_after", 32'(bus_req), 32'd0);
    wait_idle(20);

    // ready in the same cycle the timeout would fire: ready wins
    @(negedge clk);
    slave_delay = 7; slave_data = 32'hA5A5_0007; if_addr = 32'h600; if_left = 1; if_req = 1'b1;
    count_busy(cnt);
    chk("t5_busy_cycles", 32'(cnt), 32'd8);
    chk("t5_bus_err",  32'(bus_err), 32'd0);
    chk("t5_if_rdata", if_rdata, 32'hA5A5_0007);
    wait_idle(20);

    // wait states on a load, with the requester changing fields after grant
    @(negedge clk);
    scramble = 1'b1; slave_delay = 5; slave_data = 32'hCAFEF00D;
    dm_we = 1'b0; dm_addr = 32'h3000; dm_left = 1; dm_req = 1'b1;
    count_busy(cnt);
    chk("t6_busy_cycles", 32'(cnt), 32'd6);
    chk("t6_dm_ready", 32'(dm_ready), 32'd1);
    chk("t6_dm_rdata", dm_rdata, 32'hCAFEF00D);
    chk("t6_bus_err",  32'(bus_err), 32'd0);
    wait_idle(20);
    scramble = 1'b0;

    // reset in the middle of a data access
    @(negedge clk);
    slave_delay = -1; dm_we = 1'b0; dm_addr = 32'h6000; dm_left = 1; dm_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_busy_before_rst", 32'(bus_req), 32'd1);
    rst = 1'b0; dm_req = 1'b0; dm_left = 0;
    #1;
    chk("t7_bus_req",  32'(bus_req), 32'd0);
    chk("t7_dm_ready", 32'(dm_ready), 32'd0);
    chk("t7_bus_err",  32'(bus_err), 32'd0);
    chk("t7_dm_rdata", dm_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    slave_delay = 0; slave_data = 32'h1234_5678; dm_addr = 32'h7000; dm_left = 1; dm_req = 1'b1;
    @(posedge clk); #1;
    chk("t7_fresh_bus_addr", bus_addr, 32'h7000);
    @(posedge clk); #1;
    chk("t7_fresh_dm_ready", 32'(dm_ready), 32'd1);
    chk("t7_fresh_dm_rdata", dm_rdata, 32'h1234_5678);
    wait_idle(20);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

endmodule
